// File: rtl/ame_solver_pkg.sv
// Shared types and width helpers for the affine motion estimation linear solver.
package ame_solver_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    PIVOT = 3'd2,
    ELIM  = 3'd3,
    NORM  = 3'd4,
    DIV   = 3'd5,
    DONE  = 3'd6
  } state_t;

  localparam int DEF_DATA_BITS = 64;

  function automatic int prod_width(input int data_bits);
    return 2 * data_bits;
  endfunction

  // Normalisation shift ranges 0..data_bits.
  function automatic int shift_width(input int data_bits);
    return $clog2(data_bits + 1);
  endfunction

  localparam int DEF_PROD_W  = 2 * DEF_DATA_BITS;
  localparam int DEF_SHIFT_W = $clog2(DEF_DATA_BITS + 1);

endpackage

// File: rtl/ame_seq_divider.sv
// Iterative signed restoring divider computing (dividend <<< FRAC_BITS) / divisor,
// truncated toward zero; result ready DATA_BITS+1 cycles after start.
module ame_seq_divider #(
  parameter int DATA_BITS = 64,
  parameter int FRAC_BITS = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        start_i,
  input  logic signed [DATA_BITS-1:0] dividend_i,
  input  logic signed [DATA_BITS-1:0] divisor_i,
  output logic                        busy_o,
  output logic                        done_o,
  output logic signed [DATA_BITS-1:0] quot_o
);

  localparam int NW = DATA_BITS + FRAC_BITS;
  localparam int CW = $clog2(DATA_BITS + 1);

  typedef struct packed {
    logic [DATA_BITS-1:0] rem;
    logic [NW-1:0]        num;
  } div_st_t;

  div_st_t              st_r;
  div_st_t              step_s;
  div_st_t              ld_s;
  logic [DATA_BITS-1:0] den_r;
  logic [DATA_BITS-1:0] den_mag_s;
  logic [DATA_BITS-1:0] num_mag_s;
  logic [CW-1:0]        cnt_r;
  logic                 neg_r;
  logic                 busy_r;

  // One restoring step: shift in the next dividend bit, subtract when it fits.
  function automatic div_st_t div_step(input div_st_t st, input logic [DATA_BITS-1:0] den);
    div_st_t              nx;
    logic [DATA_BITS:0]   sh;
    sh = {st.rem, st.num[NW-1]};
    if (sh >= {1'b0, den}) begin
      nx.rem = DATA_BITS'(sh - {1'b0, den});
      nx.num = {st.num[NW-2:0], 1'b1};
    end else begin
      nx.rem = sh[DATA_BITS-1:0];
      nx.num = {st.num[NW-2:0], 1'b0};
    end
    return nx;
  endfunction

  assign num_mag_s = dividend_i[DATA_BITS-1] ? DATA_BITS'(-dividend_i) : DATA_BITS'(dividend_i);
  assign den_mag_s = divisor_i[DATA_BITS-1]  ? DATA_BITS'(-divisor_i)  : DATA_BITS'(divisor_i);

  // The fractional bits are resolved in the load cycle so the loop needs DATA_BITS steps.
  always_comb begin
    ld_s.rem = '0;
    ld_s.num = NW'(num_mag_s) << FRAC_BITS;
    for (int i = 0; i < FRAC_BITS; i++) begin
      ld_s = div_step(ld_s, den_mag_s);
    end
  end

  assign step_s = div_step(st_r, den_r);

  // Operand load and iteration registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      st_r   <= '0;
      den_r  <= '0;
      cnt_r  <= '0;
      neg_r  <= 1'b0;
      busy_r <= 1'b0;
    end else if (start_i && !busy_r) begin
      st_r   <= ld_s;
      den_r  <= den_mag_s;
      neg_r  <= dividend_i[DATA_BITS-1] ^ divisor_i[DATA_BITS-1];
      cnt_r  <= CW'(DATA_BITS);
      busy_r <= 1'b1;
    end else if (busy_r) begin
      st_r   <= step_s;
      cnt_r  <= cnt_r - CW'(1);
      busy_r <= (cnt_r != CW'(1));
    end else begin
      st_r   <= st_r;
      busy_r <= 1'b0;
    end
  end

  assign busy_o = busy_r;
  assign done_o = busy_r && (cnt_r == CW'(1));
  assign quot_o = DATA_BITS'(neg_r ? -step_s.num : step_s.num);

endmodule

// File: rtl/ame_linear_solver_n.sv
// Fraction-free Gauss-Jordan solver for A*x=b on the lower-right k x k block.
// Define AME_SOLVER_MAXPIVOT_EN to pick the largest-magnitude pivot instead of the first nonzero.
module ame_linear_solver_n
  import ame_solver_pkg::*;
#(
  parameter int N_MAX     = 6,
  parameter int DATA_BITS = 64,
  parameter int FRAC_BITS = 4,
  parameter int IDX_BITS  = $clog2(N_MAX + 1)
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                in_valid_i,
  output logic                                in_ready_o,
  input  logic [IDX_BITS-1:0]                 n_active_i,
  input  logic [N_MAX*(N_MAX+1)*DATA_BITS-1:0] mat_i,
  output logic                                out_valid_o,
  input  logic                                out_ready_i,
  output logic [N_MAX*DATA_BITS-1:0]          out_data_o,
  output logic                                out_singular_o,
  output logic                                busy_o
);

  localparam int PW = prod_width(DATA_BITS);
  localparam int SW = shift_width(DATA_BITS);
  localparam int NC = N_MAX + 1;
  localparam logic [IDX_BITS-1:0] N_IDX    = IDX_BITS'(N_MAX);
  localparam logic [IDX_BITS-1:0] LAST_COL = IDX_BITS'(N_MAX - 1);

  typedef logic signed [DATA_BITS-1:0] word_t;
  typedef logic signed [PW-1:0]        wide_t;

  state_t              state_r, state_s;
  word_t               mat_r   [N_MAX][NC];
  wide_t               prod_r  [N_MAX][NC];
  wide_t               prod_s  [N_MAX][NC];
  word_t               norm_s  [N_MAX][NC];
  logic [SW-1:0]       shamt_s [N_MAX];
  word_t               x_r     [N_MAX];
  logic [IDX_BITS-1:0] piv_row_r [N_MAX];
  logic [IDX_BITS-1:0] k_r, col_r, pr_r, pick_s, first_col_s, k_clamp_s;
  logic [N_MAX-1:0]    used_r;
  logic                found_s, cand_s, take_s, accept_s, last_col_s;
  logic                in_ready_r, out_valid_r, singular_r, busy_r;
  logic                div_start_s, div_busy_s, div_done_s;
  word_t               div_quot_s, div_num_s, div_den_s, piv_val_s;
`ifdef AME_SOLVER_MAXPIVOT_EN
  logic [DATA_BITS-1:0] best_s;

  function automatic logic [DATA_BITS-1:0] mag(input word_t v);
    return v[DATA_BITS-1] ? DATA_BITS'(-v) : DATA_BITS'(v);
  endfunction
`endif

  function automatic wide_t sext(input word_t v);
    return {{(PW-DATA_BITS){v[DATA_BITS-1]}}, v};
  endfunction

  // Smallest right shift that brings v back into DATA_BITS signed.
  function automatic logic [SW-1:0] shift_need(input wide_t v);
    logic [SW-1:0] s;
    s = '0;
    for (int p = DATA_BITS - 1; p < PW - 1; p++) begin
      s = (v[p] != v[PW-1]) ? SW'(p - DATA_BITS + 2) : s;
    end
    return s;
  endfunction

  assign first_col_s = N_IDX - k_r;
  assign last_col_s  = (col_r == LAST_COL);
  assign accept_s    = (state_r == IDLE) && in_valid_i && in_ready_r;
  assign piv_val_s   = mat_r[pr_r][col_r];

  // Clamp requested size into 1..N_MAX.
  always_comb begin
    if (n_active_i == '0) begin
      k_clamp_s = IDX_BITS'(1);
    end else if (n_active_i > N_IDX) begin
      k_clamp_s = N_IDX;
    end else begin
      k_clamp_s = n_active_i;
    end
  end

  // Pivot search over unused active rows of the current column.
  always_comb begin
    found_s = 1'b0;
    pick_s  = '0;
    cand_s  = 1'b0;
    take_s  = 1'b0;
`ifdef AME_SOLVER_MAXPIVOT_EN
    best_s  = '0;
`endif
    for (int r = 0; r < N_MAX; r++) begin
      cand_s = (IDX_BITS'(r) >= first_col_s) && !used_r[r] && (mat_r[r][col_r] != '0);
`ifdef AME_SOLVER_MAXPIVOT_EN
      take_s = cand_s && (!found_s || (mag(mat_r[r][col_r]) > best_s));
      best_s = take_s ? mag(mat_r[r][col_r]) : best_s;
`else
      take_s = cand_s && !found_s;
`endif
      pick_s  = take_s ? IDX_BITS'(r) : pick_s;
      found_s = found_s | take_s;
    end
  end

  // Cross-multiply elimination of the pivot column from every other active row.
  always_comb begin
    for (int i = 0; i < N_MAX; i++) begin
      for (int j = 0; j < NC; j++) begin
        if ((IDX_BITS'(i) >= first_col_s) && (IDX_BITS'(i) != pr_r)) begin
          prod_s[i][j] = sext(mat_r[i][j]) * sext(piv_val_s)
                       - sext(mat_r[pr_r][j]) * sext(mat_r[i][col_r]);
        end else begin
          prod_s[i][j] = sext(mat_r[i][j]);
        end
      end
    end
  end

  // Per-row shift back into DATA_BITS.
  always_comb begin
    for (int i = 0; i < N_MAX; i++) begin
      shamt_s[i] = '0;
      for (int j = 0; j < NC; j++) begin
        shamt_s[i] = (shift_need(prod_r[i][j]) > shamt_s[i]) ? shift_need(prod_r[i][j]) : shamt_s[i];
      end
      for (int j = 0; j < NC; j++) begin
        norm_s[i][j] = DATA_BITS'(prod_r[i][j] >>> shamt_s[i]);
      end
    end
  end

  assign div_num_s   = mat_r[piv_row_r[col_r]][N_MAX];
  assign div_den_s   = mat_r[piv_row_r[col_r]][col_r];
  assign div_start_s = (state_r == DIV) && !div_busy_s;

  ame_seq_divider #(
    .DATA_BITS (DATA_BITS),
    .FRAC_BITS (FRAC_BITS)
  ) u_div (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .start_i    (div_start_s),
    .dividend_i (div_num_s),
    .divisor_i  (div_den_s),
    .busy_o     (div_busy_s),
    .done_o     (div_done_s),
    .quot_o     (div_quot_s)
  );

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    state_s = accept_s ? LOAD : IDLE;
      LOAD:    state_s = PIVOT;
      PIVOT:   state_s = found_s ? ELIM : DONE;
      ELIM:    state_s = NORM;
      NORM:    state_s = last_col_s ? DIV : PIVOT;
      DIV:     state_s = (div_done_s && last_col_s) ? DONE : DIV;
      DONE:    state_s = out_ready_i ? IDLE : DONE;
      default: state_s = IDLE;
    endcase
  end

  // Datapath registers and registered handshake outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int r = 0; r < N_MAX; r++) begin
        x_r[r]       <= '0;
        piv_row_r[r] <= '0;
        for (int c = 0; c < NC; c++) begin
          mat_r[r][c]  <= '0;
          prod_r[r][c] <= '0;
        end
      end
      k_r         <= IDX_BITS'(1);
      col_r       <= '0;
      pr_r        <= '0;
      used_r      <= '0;
      singular_r  <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      in_ready_r  <= (state_s == IDLE);
      out_valid_r <= (state_s == DONE);
      busy_r      <= !((state_s == IDLE) || (state_s == DONE));
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            for (int r = 0; r < N_MAX; r++) begin
              x_r[r] <= '0;
              for (int c = 0; c < NC; c++) begin
                mat_r[r][c] <= mat_i[(r*NC+c)*DATA_BITS +: DATA_BITS];
              end
            end
            k_r        <= k_clamp_s;
            singular_r <= 1'b0;
          end else begin
            k_r <= k_r;
          end
        end
        LOAD: begin
          col_r  <= first_col_s;
          used_r <= '0;
        end
        PIVOT: begin
          if (found_s) begin
            used_r[pick_s]   <= 1'b1;
            piv_row_r[col_r] <= pick_s;
            pr_r             <= pick_s;
          end else begin
            singular_r <= 1'b1;
            for (int r = 0; r < N_MAX; r++) begin
              x_r[r] <= '0;
            end
          end
        end
        ELIM: prod_r <= prod_s;
        NORM: begin
          mat_r <= norm_s;
          col_r <= last_col_s ? first_col_s : col_r + IDX_BITS'(1);
        end
        DIV: begin
          if (div_done_s) begin
            x_r[col_r] <= div_quot_s;
            col_r      <= last_col_s ? col_r : col_r + IDX_BITS'(1);
          end else begin
            col_r <= col_r;
          end
        end
        DONE:    col_r <= col_r;
        default: col_r <= '0;
      endcase
    end
  end

  for (genvar c = 0; c < N_MAX; c++) begin : g_out
    assign out_data_o[c*DATA_BITS +: DATA_BITS] = x_r[c];
  end

  assign in_ready_o     = in_ready_r;
  assign out_valid_o    = out_valid_r;
  assign out_singular_o = singular_r;
  assign busy_o         = busy_r;

endmodule

// File: tb/tb_ame_linear_solver_n.sv
// Bench for ame_linear_solver_n: directed cases plus random small systems checked by Cramer's rule.
module tb_ame_linear_solver_n;

  localparam int N  = 6;
  localparam int NC = 7;
  localparam int DB = 64;

  typedef longint m3_t [3][3];

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        n_active;
  logic [N*NC*DB-1:0] mat;
  logic              out_valid;
  logic              out_ready;
  logic [N*DB-1:0]   out_data;
  logic              out_singular;
  logic              busy;

  int     total = 0;
  int     bad   = 0;
  longint am   [N][NC];
  longint expx [N];
  logic   exp_sing;
  int     lat;

  ame_linear_solver_n dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .in_valid_i     (in_valid),
    .in_ready_o     (in_ready),
    .n_active_i     (n_active),
    .mat_i          (mat),
    .out_valid_o    (out_valid),
    .out_ready_i    (out_ready),
    .out_data_o     (out_data),
    .out_singular_o (out_singular),
    .busy_o         (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic clear_all();
    for (int r = 0; r < N; r++) begin
      expx[r] = 0;
      for (int c = 0; c < NC; c++) am[r][c] = 0;
    end
    exp_sing = 1'b0;
  endtask

  task automatic load_bus();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < NC; c++)
        mat[(r*NC+c)*DB +: DB] = am[r][c];
  endtask

  function automatic longint det3(input m3_t m);
    return m[0][0]*(m[1][1]*m[2][2] - m[1][2]*m[2][1])
         - m[0][1]*(m[1][0]*m[2][2] - m[1][2]*m[2][0])
         + m[0][2]*(m[1][0]*m[2][1] - m[1][1]*m[2][0]);
  endfunction

  // Cramer's rule on rows/cols 3..5, active block padded with identity.
  task automatic model(input int k);
    m3_t    m, mc;
    longint bv [3];
    longint d, dc;
    int     kk, t;
    kk = (k == 0) ? 1 : k;
    t  = 3 - kk;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++)
        m[i][j] = (i < t || j < t) ? ((i == j) ? 64'sd1 : 64'sd0) : am[3+i][3+j];
      bv[i] = (i < t) ? 64'sd0 : am[3+i][6];
    end
    d = det3(m);
    exp_sing = (d == 0);
    for (int c = 0; c < N; c++) expx[c] = 0;
    if (d != 0) begin
      for (int cc = t; cc < 3; cc++) begin
        mc = m;
        for (int i = 0; i < 3; i++) mc[i][cc] = bv[i];
        dc = det3(mc);
        expx[3+cc] = (dc * 16) / d;
      end
    end
  endtask

  task automatic send(input logic [2:0] k, output int l);
    load_bus();
    n_active = k;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    l = 1;
    while (!out_valid && l < 2000) begin
      @(posedge clk); #1;
      l++;
    end
    chk("out_valid_seen", {63'd0, out_valid}, 64'd1);
  endtask

  task automatic check_result(input string tag);
    for (int c = 0; c < N; c++)
      chk($sformatf("%s_x%0d", tag, c), out_data[c*DB +: DB], expx[c]);
    chk({tag, "_singular"}, {63'd0, out_singular}, {63'd0, exp_sing});
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("hs_in_ready", {63'd0, in_ready}, 64'd1);
    chk("hs_out_valid", {63'd0, out_valid}, 64'd0);
  endtask

  task automatic setup_t1();
    clear_all();
    am[4][4] = 2; am[4][5] = 1; am[4][6] = 5;
    am[5][4] = 1; am[5][5] = 3; am[5][6] = 10;
    expx[4] = 16; expx[5] = 48;
  endtask

  task automatic setup_diag3();
    clear_all();
    for (int i = 0; i < N; i++) begin
      am[i][i] = 3;
      am[i][6] = 3 * (i + 1);
      expx[i]  = 16 * (i + 1);
    end
  endtask

  initial begin
    int k;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; n_active = 3'd0; mat = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_singular", {63'd0, out_singular}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_data_zero", {63'd0, |out_data}, 64'd0);

    setup_t1();
    send(3'd2, lat);
    chk("t1_latency", 64'(lat), 64'd138);
    check_result("t1");
    handshake();

    clear_all();
    am[4][4] = 1; am[4][5] = 2; am[4][6] = 3;
    am[5][4] = 2; am[5][5] = 4; am[5][6] = 6;
    exp_sing = 1'b1;
    send(3'd2, lat);
    check_result("t2");
    handshake();

    setup_diag3();
    send(3'd6, lat);
    chk("t3_latency", 64'(lat), 64'd410);
    check_result("t3");
    handshake();

    setup_diag3();
    send(3'd7, lat);
    check_result("t3_clamp7");
    handshake();

    clear_all();
    am[4][5] = 1; am[4][6] = 2;
    am[5][4] = 1; am[5][6] = 3;
    expx[4] = 48; expx[5] = 32;
    send(3'd2, lat);
    check_result("t4");
    handshake();

    clear_all();
    am[5][5] = 4; am[5][6] = 8; am[4][4] = 9; am[4][6] = 7;
    model(0);
    send(3'd0, lat);
    chk("k0_x5_value", 64'(expx[5]), 64'd32);
    check_result("k0");
    handshake();

    setup_t1();
    send(3'd2, lat);
    setup_diag3();
    load_bus();
    n_active = 3'd6;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      chk("t5_valid_hold", {63'd0, out_valid}, 64'd1);
      chk("t5_in_ready", {63'd0, in_ready}, 64'd0);
      chk("t5_x4_hold", out_data[4*DB +: DB], 64'd16);
      chk("t5_x5_hold", out_data[5*DB +: DB], 64'd48);
    end
    in_valid = 1'b0;
    handshake();
    repeat (3) @(posedge clk);
    #1;
    chk("t5_no_new_busy", {63'd0, busy}, 64'd0);
    chk("t5_no_new_valid", {63'd0, out_valid}, 64'd0);

    setup_t1();
    load_bus();
    n_active = 3'd2;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("t6_busy_in_elim", {63'd0, busy}, 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("t6_in_ready", {63'd0, in_ready}, 64'd1);
    chk("t6_out_valid", {63'd0, out_valid}, 64'd0);
    chk("t6_busy", {63'd0, busy}, 64'd0);
    setup_t1();
    send(3'd2, lat);
    check_result("t6_after");
    handshake();

    for (int it = 0; it < 12; it++) begin
      clear_all();
      k = int'($urandom_range(1, 3));
      for (int r = 0; r < N; r++)
        for (int c = 0; c < NC; c++)
          am[r][c] = longint'($urandom_range(0, 6)) - 64'sd3;
      model(k);
      send(3'(k), lat);
      if (!exp_sing) chk("rnd_latency", 64'(lat), 64'(2 + 3*k + 65*k));
      else chk("rnd_sing_early", {63'd0, (lat <= 2 + 3*k + 65*k)}, 64'd1);
      check_result($sformatf("rnd%0d", it));
      handshake();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
